// File: rtl/cnn_conv_mac_sched_pkg.sv
// ---------------------------------------------------------------------------
// cnn_conv_mac_pkg
//   Shared widths, kernel length, the scheduler state encoding and the output
//   saturation helper for the conv1 MAC scheduler.
//   No ports (package).
// ---------------------------------------------------------------------------
package cnn_conv_mac_pkg;

    localparam int KLEN   = 25;   // multiply-accumulates per result (5x5)
    localparam int ADDR_W = 5;    // BRAM address width, 2**ADDR_W >= KLEN
    localparam int A_W    = 9;    // unsigned pixel width
    localparam int B_W    = 14;   // signed weight / bias width
    localparam int P_W    = 23;   // signed product width
    localparam int ACC_W  = 28;   // signed accumulator width
    localparam int SHIFT  = 8;    // arithmetic right shift before saturation
    localparam int OUT_W  = 16;   // signed result width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Clamp an already-shifted accumulator value into the signed OUT_W range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = ACC_W'(2**(OUT_W-1) - 1);
        lo = ~hi;
        if (v > hi) begin
            sat_out = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (v < lo) begin
            sat_out = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_out = v[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/cnn_conv_mac_sched_if.sv
// ---------------------------------------------------------------------------
// cnn_conv_mac_sched_if
//   Control, bias/result and BRAM read bus of the conv1 MAC scheduler.
//   master : the scheduler (drives control strobes, BRAM addresses, result)
//   slave  : the surroundings (start/bias source, BRAMs, result consumer)
//
//   Handshake: ap_start is a level request looked at only while ap_idle=1;
//   the block answers with a one-cycle ap_done/ap_ready/result_vld pulse and
//   result is valid during that pulse. BRAM reads have no backpressure:
//   pix_q/w_q return the word addressed one cycle earlier while *_ce was high.
// ---------------------------------------------------------------------------
interface cnn_conv_mac_sched_if;
    import cnn_conv_mac_pkg::*;

    logic                     ap_start;
    logic                     ap_done;
    logic                     ap_idle;
    logic                     ap_ready;
    logic signed [B_W-1:0]    bias;
    logic [ADDR_W-1:0]        pix_addr;
    logic                     pix_ce;
    logic [A_W-1:0]           pix_q;
    logic [ADDR_W-1:0]        w_addr;
    logic                     w_ce;
    logic signed [B_W-1:0]    w_q;
    logic signed [OUT_W-1:0]  result;
    logic                     result_vld;

    modport master (
        input  ap_start, bias, pix_q, w_q,
        output ap_done, ap_idle, ap_ready, pix_addr, pix_ce,
               w_addr, w_ce, result, result_vld
    );

    modport slave (
        output ap_start, bias, pix_q, w_q,
        input  ap_done, ap_idle, ap_ready, pix_addr, pix_ce,
               w_addr, w_ce, result, result_vld
    );

endinterface

// File: rtl/cnn_conv_mac_sched_mul.sv
// ---------------------------------------------------------------------------
// cnn_conv_mac_mul_9u14s
//   Combinational 9-bit unsigned x 14-bit signed multiplier. The product is
//   registered by the parent so the pipeline register folds into the DSP.
//   i_a : unsigned pixel
//   i_b : signed weight
//   o_p : signed product, P_W bits (always exact for these input ranges)
// ---------------------------------------------------------------------------
module cnn_conv_mac_mul_9u14s
    import cnn_conv_mac_pkg::*;
(
    input  logic [A_W-1:0]         i_a,
    input  logic signed [B_W-1:0]  i_b,
    output logic signed [P_W-1:0]  o_p
);

    logic signed [P_W-1:0] w_a_x;
    logic signed [P_W-1:0] w_b_x;

    // The pixel is zero-extended so it is never read as negative; the weight
    // keeps its sign. Both are widened to the product width before multiply.
    assign w_a_x = {{(P_W-A_W){1'b0}}, i_a};
    assign w_b_x = {{(P_W-B_W){i_b[B_W-1]}}, i_b};
    assign o_p   = w_a_x * w_b_x;

endmodule

// File: rtl/cnn_conv_mac_sched.sv
// ---------------------------------------------------------------------------
// cnn_conv_mac_sched
//   Runs one conv kernel dot product through a single shared multiplier:
//   issues KLEN pixel/weight BRAM reads, multiplies and accumulates them on
//   top of a pre-shifted bias, then shifts, saturates and emits one pixel.
//   ap_clk      : clock, rising edge
//   ap_rst_n    : asynchronous active-low reset
//   bus         : control / bias / result / BRAM read bus (master side)
//   o_dbg_state : current scheduler state
// ---------------------------------------------------------------------------
module cnn_conv_mac_sched
    import cnn_conv_mac_pkg::*;
(
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    cnn_conv_mac_sched_if.master   bus,
    output state_t                 o_dbg_state
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDR_W-1:0]        r_cnt;
    logic                     r_dcnt;
    logic                     r_v1;
    logic                     r_v2;
    logic signed [P_W-1:0]    r_p;
    logic signed [P_W-1:0]    w_p;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_acc_sh;
    logic signed [ACC_W-1:0]  w_bias_sh;
    logic signed [OUT_W-1:0]  w_sat;
    logic signed [OUT_W-1:0]  r_result;
    logic                     w_start;
    logic                     w_last;
    logic                     w_ce;
    logic                     w_done;
    logic                     w_idle;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last = (r_cnt == ADDR_W'(KLEN-1));

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ce        = 1'b0;
        w_done      = 1'b0;
        w_idle      = 1'b0;
        case (r_state)
            IDLE: begin
                w_idle = 1'b1;
                if (bus.ap_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_ce = 1'b1;
                if (w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Two cycles let the last read pass the BRAM and product stages.
                if (r_dcnt) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address and drain counters. The address counter stops at KLEN-1 and
    // holds there between operations, so addresses stay stable with ce low.
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_cnt  <= '0;
            r_dcnt <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (w_last) begin
                        r_dcnt <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    r_dcnt <= ~r_dcnt;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath pipeline: v1 marks cycles where BRAM data is valid, v2 marks
    // cycles where the registered product is valid.
    // ------------------------------------------------------------------
    cnn_conv_mac_mul_9u14s u_mul (
        .i_a (bus.pix_q),
        .i_b (bus.w_q),
        .o_p (w_p)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_p  <= '0;
        end else begin
            r_v1 <= (r_state == ISSUE);
            r_v2 <= r_v1;
            if (r_v1) begin
                r_p <= w_p;
            end
        end
    end

    // Bias is pre-scaled by SHIFT so the final right shift returns it unscaled.
    assign w_bias_sh = {{(ACC_W-B_W){bus.bias[B_W-1]}}, bus.bias} <<< SHIFT;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc <= '0;
        end else if (w_start) begin
            r_acc <= w_bias_sh;
        end else if (r_v2) begin
            r_acc <= r_acc + {{(ACC_W-P_W){r_p[P_W-1]}}, r_p};
        end
    end

    // ------------------------------------------------------------------
    // Output. The accumulator is final on the OUT cycle, so the saturated
    // value is shown directly during the done pulse and captured at its end;
    // the capture keeps the result steady until the next OUT.
    // ------------------------------------------------------------------
    assign w_acc_sh = r_acc >>> SHIFT;
    assign w_sat    = sat_out(w_acc_sh);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_result <= '0;
        end else if (r_state == OUT) begin
            r_result <= w_sat;
        end
    end

    assign bus.result     = (r_state == OUT) ? w_sat : r_result;
    assign bus.ap_done    = w_done;
    assign bus.ap_ready   = w_done;
    assign bus.result_vld = w_done;
    assign bus.ap_idle    = w_idle;
    assign bus.pix_addr   = r_cnt;
    assign bus.w_addr     = r_cnt;
    assign bus.pix_ce     = w_ce;
    assign bus.w_ce       = w_ce;
    assign o_dbg_state    = r_state;

endmodule
